muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative RV32M/RV64M multiply-divide unit, used alongside the ID/EX control path. The single-cycle ALU handles only MUL; this block executes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles. It raises a pipeline stall while it runs and returns one XLEN result with a done pulse.

Parameters:
XLEN, 32, operand/result width; must be 32 or 64
STEP_BITS, 1, quotient/multiplier bits retired per CALC cycle; must divide XLEN (1, 2 or 4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
funct3  in  3  M-op select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
rs1_val  in  XLEN  operand A / dividend
rs2_val  in  XLEN  operand B / divisor
flush  in  1  abort current op (branch mispredict / redirect)
busy  out  1  high in PREP, CALC, FIX
stall_ID  out  1  = busy | (start & IDLE), combinational
done  out  1  one-cycle pulse, result valid
result  out  XLEN  result; held stable from done until next accepted start

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if start & !flush, latch funct3 and operands, go to PREP. A start while not IDLE is ignored.
- PREP (1 cycle): compute operand signs per op (MULH both signed, MULHSU rs1 signed only, DIV/REM both signed) and take absolute values. Load iteration counter = XLEN/STEP_BITS. Special cases go straight to DONE with the result preloaded:
  divisor==0: DIV/DIVU quotient = all ones; REM/REMU = rs1_val.
  signed overflow (rs1 = most-negative, rs2 = -1): DIV = rs1_val; REM = 0.
- CALC: each cycle retires STEP_BITS bits. Multiply uses add-shift into a 2*XLEN product. Divide is restoring: shift the remainder, trial-subtract, set the quotient bit. The counter decrements each cycle. When it reaches 0, go to FIX.
- FIX (1 cycle): negate the result when the sign rule requires it. Quotient sign = signA^signB. Remainder sign = signA. Product sign = signA^signB under the op's signedness. Select the low half for MUL, the high half for MULH*, the quotient or the remainder for divides. Go to DONE.
- DONE (1 cycle): done=1, result registered, go to IDLE.
- Latency, start to done: XLEN/STEP_BITS+3 cycles (35 for defaults); special cases take 2 cycles.
- flush in PREP/CALC/FIX: next state IDLE, no done, result unchanged. flush in DONE does not suppress done (the op has already completed). flush with start in IDLE: start is ignored.
- Arithmetic is modulo 2^XLEN. Internal datapath is XLEN+1 bits for the divide trial-subtract and 2*XLEN bits for the product.
- Reset mid-operation: immediate IDLE, done never issued.

Decomposition:
- Shared riscv_defs.vh gets the M-op funct3 constants (`MD_MUL .. `MD_REMU), the MULDIV funct7 value (7'b0000001) and the state encodings.
- One sub-module, muldiv_step: combinational, one STEP_BITS iteration for either mul (add-shift) or div (restoring), parametrised by XLEN and STEP_BITS, instantiated once.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 35 cycles after start, stall_ID high through the op.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Each done 2 cycles after start.
- flush asserted at CALC cycle 10 -> IDLE next cycle, no done pulse, result keeps its previous value. A new start 1 cycle later completes correctly.
- rst_n low mid-CALC -> busy=0, done=0, result=0 asynchronously. start held during busy is ignored (no second done). Repeat the scenarios with STEP_BITS=2 and STEP_BITS=4, and with XLEN=64 and 64-bit analogues.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative M-extension unit: op encodings, FSM states
// and helpers that decode operand signedness from funct3.
package muldiv_sequencer_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the ID/EX control path (master) and the
// multiply-divide sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            busy;
  logic            stall_ID;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  busy, stall_ID, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output busy, stall_ID, done, result
  );
endinterface

// File: rtl/muldiv_step.sv
// One CALC cycle of the sequencer: STEP_BITS rounds of add-shift multiply or
// restoring divide on the shared {hi, lo} accumulator.
module muldiv_step #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0]        work;
  logic [XLEN:0]            r_sh;
  logic [XLEN-1:0]          diff;
  logic                     ge;
  logic [XLEN+STEP_BITS-1:0] ext;
  logic [XLEN+STEP_BITS-1:0] addend;
  logic [XLEN+STEP_BITS-1:0] sum;

  always_comb begin
    work   = acc_i;
    r_sh   = '0;
    diff   = '0;
    ge     = 1'b0;
    ext    = {{STEP_BITS{1'b0}}, opnd_i};
    addend = '0;
    sum    = '0;
    acc_o  = acc_i;
    if (div_i) begin
      // hi holds the partial remainder, lo shifts the dividend out and quotient bits in
      for (int k = 0; k < STEP_BITS; k++) begin
        r_sh = {work[2*XLEN-1:XLEN], work[XLEN-1]};
        ge   = (r_sh >= {1'b0, opnd_i});
        diff = r_sh[XLEN-1:0] - opnd_i;
        work = {(ge ? diff : r_sh[XLEN-1:0]), work[XLEN-2:0], ge};
      end
      acc_o = work;
    end else begin
      // low STEP_BITS of the multiplier form one digit; its partial product joins hi
      for (int j = 0; j < STEP_BITS; j++) begin
        if (acc_i[j]) addend = addend + (ext << j);
      end
      sum   = {{STEP_BITS{1'b0}}, acc_i[2*XLEN-1:XLEN]} + addend;
      acc_o = {sum, acc_i[XLEN-1:STEP_BITS]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M/RV64M multiply-divide unit: sign-magnitude prep, XLEN/STEP_BITS
// iterations, sign fix-up, then a one-cycle done pulse with a held result.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  muldiv_sequencer_if.slave    md
);

  localparam int ITER  = XLEN / STEP_BITS;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_C  = CNT_W'(ITER);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   a_raw, b_raw, abs_a, abs_b, fix_res;
  logic              sa, sb, op_div, div0, ovf;

  muldiv_step #(
    .XLEN      (XLEN),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .div_i  (op_div),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Raw operands sit in acc lo / opnd between IDLE and PREP
  assign op_div   = op_q[2];
  assign a_raw    = acc_q[XLEN-1:0];
  assign b_raw    = opnd_q;
  assign sa       = rs1_signed(op_q) & a_raw[XLEN-1];
  assign sb       = rs2_signed(op_q) & b_raw[XLEN-1];
  assign abs_a    = sa ? -a_raw : a_raw;
  assign abs_b    = sb ? -b_raw : b_raw;
  assign div0     = (b_raw == '0);
  assign ovf      = ((op_q == MD_DIV) || (op_q == MD_REM)) && (a_raw == MIN_NEG) && (b_raw == '1);
  assign prod_neg = -acc_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      MD_MUL:                        fix_res = neg_q ? prod_neg[XLEN-1:0] : acc_q[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = neg_q ? prod_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                       fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start && !md.flush) begin
          state_d = ST_PREP;
          op_d    = md.funct3;
          acc_d   = {{XLEN{1'b0}}, md.rs1_val};
          opnd_d  = md.rs2_val;
        end
      end
      ST_PREP: begin
        if (md.flush) begin
          state_d = ST_IDLE;
        end else if (op_div && div0) begin
          res_d   = op_q[1] ? a_raw : '1;
          state_d = ST_DONE;
        end else if (ovf) begin
          res_d   = op_q[1] ? '0 : a_raw;
          state_d = ST_DONE;
        end else begin
          acc_d   = {{XLEN{1'b0}}, abs_a};
          opnd_d  = abs_b;
          neg_d   = (op_q[2] && op_q[1]) ? sa : (sa ^ sb);
          cnt_d   = ITER_C;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (md.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (md.flush) begin
          state_d = ST_IDLE;
        end else begin
          res_d   = fix_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign md.busy     = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX);
  assign md.stall_ID = md.busy || (md.start && (state_q == ST_IDLE));
  assign md.done     = (state_q == ST_DONE);
  assign md.result   = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench: three 32-bit units (STEP_BITS 1/2/4) share one request stream,
// plus a 64-bit unit (STEP_BITS 2) driven separately.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic        sp;
  } vec32_t;

  typedef struct packed {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    logic        sp;
  } vec64_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] a32, b32;
  logic        start64, flush64;
  logic [2:0]  f64;
  logic [63:0] a64, b64;

  int checks = 0;
  int errors = 0;

  int          lat1, lat2, lat4, nd1, nd2, nd4, lat64, nd64;
  logic [31:0] res1, res2, res4;
  logic [63:0] res64;
  bit          stall0, stall_ok;

  muldiv_sequencer_if #(.XLEN(32)) bus1 ();
  muldiv_sequencer_if #(.XLEN(32)) bus2 ();
  muldiv_sequencer_if #(.XLEN(32)) bus4 ();
  muldiv_sequencer_if #(.XLEN(64)) bus64 ();

  assign bus1.start = start;  assign bus1.funct3 = funct3;  assign bus1.rs1_val = a32;
  assign bus1.rs2_val = b32;  assign bus1.flush = flush;
  assign bus2.start = start;  assign bus2.funct3 = funct3;  assign bus2.rs1_val = a32;
  assign bus2.rs2_val = b32;  assign bus2.flush = flush;
  assign bus4.start = start;  assign bus4.funct3 = funct3;  assign bus4.rs1_val = a32;
  assign bus4.rs2_val = b32;  assign bus4.flush = flush;
  assign bus64.start = start64; assign bus64.funct3 = f64; assign bus64.rs1_val = a64;
  assign bus64.rs2_val = b64;   assign bus64.flush = flush64;

  muldiv_sequencer #(.XLEN(32), .STEP_BITS(1)) u_s1  (.clk(clk), .rst_n(rst_n), .md(bus1));
  muldiv_sequencer #(.XLEN(32), .STEP_BITS(2)) u_s2  (.clk(clk), .rst_n(rst_n), .md(bus2));
  muldiv_sequencer #(.XLEN(32), .STEP_BITS(4)) u_s4  (.clk(clk), .rst_n(rst_n), .md(bus4));
  muldiv_sequencer #(.XLEN(64), .STEP_BITS(2)) u_s64 (.clk(clk), .rst_n(rst_n), .md(bus64));

  // Cycle 0 is the cycle start is presented; outputs are sampled 1ns after each negedge.
  task automatic issue32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f; a32 = a; b32 = b;
    #1;
    stall0 = bus1.stall_ID && bus2.stall_ID && bus4.stall_ID;
    stall_ok = 1'b1;
    lat1 = -1; lat2 = -1; lat4 = -1; nd1 = 0; nd2 = 0; nd4 = 0;
    res1 = 'x; res2 = 'x; res4 = 'x;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (bus1.done) begin nd1++; if (lat1 < 0) begin lat1 = cyc; res1 = bus1.result; end end
      else if (lat1 < 0 && !bus1.stall_ID) stall_ok = 1'b0;
      if (bus2.done) begin nd2++; if (lat2 < 0) begin lat2 = cyc; res2 = bus2.result; end end
      else if (lat2 < 0 && !bus2.stall_ID) stall_ok = 1'b0;
      if (bus4.done) begin nd4++; if (lat4 < 0) begin lat4 = cyc; res4 = bus4.result; end end
      else if (lat4 < 0 && !bus4.stall_ID) stall_ok = 1'b0;
    end
  endtask

  task automatic issue64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input bit hold);
    @(negedge clk);
    start64 = 1'b1; f64 = f; a64 = a; b64 = b;
    lat64 = -1; nd64 = 0; res64 = 'x;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (!hold) start64 = 1'b0;
      #1;
      if (bus64.done) begin
        nd64++;
        start64 = 1'b0;
        if (lat64 < 0) begin lat64 = cyc; res64 = bus64.result; end
      end
    end
    start64 = 1'b0;
  endtask

  task automatic check_vectors32(input string tag, input vec32_t v);
    int e1, e2, e4;
    issue32(v.f, v.a, v.b);
    e1 = v.sp ? 2 : 35; e2 = v.sp ? 2 : 19; e4 = v.sp ? 2 : 11;
    checks++; if (res1 !== v.e) begin errors++; $display("FAIL %s s1 result got %h expected %h", tag, res1, v.e); end
    checks++; if (res2 !== v.e) begin errors++; $display("FAIL %s s2 result got %h expected %h", tag, res2, v.e); end
    checks++; if (res4 !== v.e) begin errors++; $display("FAIL %s s4 result got %h expected %h", tag, res4, v.e); end
    checks++;
    if (lat1 != e1 || lat2 != e2 || lat4 != e4) begin
      errors++; $display("FAIL %s latency got %0d/%0d/%0d expected %0d/%0d/%0d", tag, lat1, lat2, lat4, e1, e2, e4);
    end
    checks++;
    if (nd1 != 1 || nd2 != 1 || nd4 != 1) begin
      errors++; $display("FAIL %s done count got %0d/%0d/%0d expected 1/1/1", tag, nd1, nd2, nd4);
    end
    checks++;
    if (!(stall0 && stall_ok)) begin
      errors++; $display("FAIL %s stall_ID got start=%0b busy=%0b expected 1/1", tag, stall0, stall_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus1.busy, bus2.busy, bus4.busy, bus64.busy, bus1.done, bus2.done, bus4.done, bus64.done} !== 8'h00) begin
      errors++; $display("FAIL reset busy/done got nonzero expected 0");
    end
    checks++;
    if ({bus1.result, bus2.result, bus4.result, bus64.result} !== 160'h0) begin
      errors++; $display("FAIL reset result got %h %h expected 0", bus1.result, bus64.result);
    end
    checks++;
    if ({bus1.stall_ID, bus64.stall_ID} !== 2'b00) begin
      errors++; $display("FAIL reset stall_ID got %b expected 00", {bus1.stall_ID, bus64.stall_ID});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multiply();
    vec32_t v [6];
    v = '{'{MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
          '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
          '{MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
          '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
          '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
          '{MD_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 1'b0}};
    for (int i = 0; i < 6; i++) check_vectors32($sformatf("mul[%0d]", i), v[i]);
  endtask

  task automatic test_divide();
    vec32_t v [10];
    v = '{'{MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
          '{MD_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
          '{MD_DIVU, 32'd100,      32'd7,        32'd14,       1'b0},
          '{MD_DIV,  32'h80000000, 32'h00000002, 32'hC0000000, 1'b0},
          '{MD_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b1},
          '{MD_REMU, 32'h00001234, 32'h00000000, 32'h00001234, 1'b1},
          '{MD_REM,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1'b1},
          '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
          '{MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},
          '{MD_REMU, 32'd100,      32'd7,        32'd2,        1'b0}};
    for (int i = 0; i < 10; i++) check_vectors32($sformatf("div[%0d]", i), v[i]);
  endtask

  // Flush lands in CALC for s1/s2 but in DONE for s4, which must still complete.
  task automatic test_flush();
    int fd1 = 0, fd2 = 0, fd4 = 0, fl4 = -1;
    logic [31:0] r4 = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = MD_MUL; a32 = 32'd7; b32 = 32'd3;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (cyc == 11);
      #1;
      if (bus1.done) fd1++;
      if (bus2.done) fd2++;
      if (bus4.done) begin fd4++; fl4 = cyc; r4 = bus4.result; end
      if (cyc == 12) begin
        checks++;
        if (bus1.busy || bus2.busy) begin
          errors++; $display("FAIL flush idle busy got %b%b expected 00", bus1.busy, bus2.busy);
        end
      end
    end
    flush = 1'b0;
    checks++;
    if (fd1 != 0 || fd2 != 0) begin errors++; $display("FAIL flush done got %0d/%0d expected 0/0", fd1, fd2); end
    checks++;
    if (bus1.result !== 32'd2 || bus2.result !== 32'd2) begin
      errors++; $display("FAIL flush held result got %h/%h expected 00000002", bus1.result, bus2.result);
    end
    checks++;
    if (fd4 != 1 || fl4 != 11 || r4 !== 32'd21) begin
      errors++; $display("FAIL flush_in_done s4 got n=%0d cyc=%0d res=%h expected 1/11/00000015", fd4, fl4, r4);
    end
    check_vectors32("after_flush", '{MD_DIVU, 32'd100, 32'd7, 32'd14, 1'b0});
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = MD_MUL; a32 = 32'd5; b32 = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (bus1.busy || bus2.busy || bus4.busy || bus1.done) begin
      errors++; $display("FAIL flush_start_idle got busy=%b%b%b done=%b expected 0", bus1.busy, bus2.busy, bus4.busy, bus1.done);
    end
  endtask

  task automatic test_reset_mid();
    int rd = 0;
    @(negedge clk);
    start = 1'b1; funct3 = MD_MUL; a32 = 32'd7; b32 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.busy, bus2.busy, bus4.busy, bus1.done, bus2.done, bus4.done} !== 6'b0) begin
      errors++; $display("FAIL reset_mid busy/done got nonzero expected 0");
    end
    checks++;
    if ({bus1.result, bus2.result, bus4.result} !== 96'h0) begin
      errors++; $display("FAIL reset_mid result got %h/%h/%h expected 0", bus1.result, bus2.result, bus4.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      #1;
      if (bus1.done || bus2.done || bus4.done) rd++;
    end
    checks++;
    if (rd != 0) begin errors++; $display("FAIL reset_mid late done got %0d expected 0", rd); end
  endtask

  task automatic test_64();
    vec64_t v [11];
    int el;
    v = '{'{MD_MUL,    64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b0},
          '{MD_MULHU,  '1,    '1,                   64'hFFFFFFFFFFFFFFFE, 1'b0},
          '{MD_MULH,   '1,    '1,                   64'h0,                1'b0},
          '{MD_MULHSU, '1,    '1,                   64'hFFFFFFFFFFFFFFFF, 1'b0},
          '{MD_DIV,    64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0},
          '{MD_REM,    64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0},
          '{MD_DIVU,   64'd100, 64'd7,              64'd14,               1'b0},
          '{MD_DIVU,   64'h1234, 64'd0,             64'hFFFFFFFFFFFFFFFF, 1'b1},
          '{MD_REMU,   64'h1234, 64'd0,             64'h1234,             1'b1},
          '{MD_DIV,    64'h8000000000000000, '1,    64'h8000000000000000, 1'b1},
          '{MD_REM,    64'h8000000000000000, '1,    64'h0,                1'b1}};
    for (int i = 0; i < 11; i++) begin
      issue64(v[i].f, v[i].a, v[i].b, 1'b0);
      el = v[i].sp ? 2 : 35;
      checks++;
      if (res64 !== v[i].e) begin errors++; $display("FAIL x64[%0d] result got %h expected %h", i, res64, v[i].e); end
      checks++;
      if (lat64 != el || nd64 != 1) begin
        errors++; $display("FAIL x64[%0d] latency/done got %0d/%0d expected %0d/1", i, lat64, nd64, el);
      end
    end
  endtask

  task automatic test_start_held();
    issue64(MD_DIVU, 64'd1000, 64'd10, 1'b1);
    checks++;
    if (res64 !== 64'd100) begin errors++; $display("FAIL start_held result got %h expected %h", res64, 64'd100); end
    checks++;
    if (nd64 != 1 || lat64 != 35) begin
      errors++; $display("FAIL start_held done got n=%0d lat=%0d expected 1/35", nd64, lat64);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; a32 = '0; b32 = '0;
    start64 = 1'b0; flush64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_flush();
    test_reset_mid();
    test_64();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
